maze_loader: RTL and testbench

- Sequences a bank of maze map ROMs (10-word, 8-bit, 1-cycle synchronous read) and loads the selected map into a register image for the game logic.
- Each load captures 8 row words, the start point and the end point, then validates the positions and signals completion.
- Sits between the map ROM bank and the player/position logic; it is the only master of ROM `en`/`addr`.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/maze_loader_if.sv | 25 ++
 rtl/maze_pos_check.sv | 22 ++
 rtl/maze_loader.sv | 142 ++++++++++++++
 tb/tb_maze_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, field slices and state enum
// for the maze map loader and its position checker.
package maze_pkg;

  localparam int MAP_WORDS = 10;
  localparam int ROW_W = 8;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_START = 4'b1000;
  localparam logic [ADDR_W-1:0] ADDR_END = 4'b1001;

  localparam int POS_W = 6;
  localparam int ROW_HI = 5;
  localparam int ROW_LO = 3;
  localparam int COL_HI = 2;
  localparam int COL_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CHECK
  } ld_state_t;

endpackage

// File: rtl/maze_loader_if.sv
// maze_loader_if: map ROM bank bus, one-hot enables,
// shared word address and per-ROM read data lanes.
interface maze_loader_if
  import maze_pkg::*;
#(
  parameter int NUM_MAPS = 4
);

  logic [NUM_MAPS-1:0] en;
  logic [ADDR_W-1:0] addr;
  logic [ROW_W*NUM_MAPS-1:0] data;

  modport master (
    output en,
    output addr,
    input data
  );

  modport slave (
    input en,
    input addr,
    output data
  );

endinterface

// File: rtl/maze_pos_check.sv
// maze_pos_check: flags a map whose start or end cell is
// closed, or whose start and end coincide.
module maze_pos_check
  import maze_pkg::*;
(
  input logic [63:0] maze_bits,
  input logic [POS_W-1:0] start_pos,
  input logic [POS_W-1:0] end_pos,
  output logic fail
);

  logic s_open;
  logic e_open;

  assign s_open = maze_bits[{start_pos[ROW_HI:ROW_LO],
                             start_pos[COL_HI:COL_LO]}];
  assign e_open = maze_bits[{end_pos[ROW_HI:ROW_LO],
                             end_pos[COL_HI:COL_LO]}];

  assign fail = ~s_open | ~e_open | (start_pos == end_pos);

endmodule

// File: rtl/maze_loader.sv
// maze_loader: reads one 10-word map ROM into the register image.
// Define MAZE_LOADER_CHECK_EN to reject bad start/end positions.
module maze_loader
  import maze_pkg::*;
#(
  parameter int NUM_MAPS = 4,
  parameter int SEL_W = 2
) (
  input logic clk,
  input logic rst_n,
  input logic load_req,
  input logic [SEL_W-1:0] map_sel,
  maze_loader_if.master rom,
  output logic [63:0] maze_bits,
  output logic [POS_W-1:0] start_pos,
  output logic [POS_W-1:0] end_pos,
  output logic busy,
  output logic done,
  output logic err,
  output logic map_valid
);

  localparam logic [SEL_W:0] N_MAPS = (SEL_W+1)'(NUM_MAPS);

  ld_state_t state;
  ld_state_t state_n;

  logic [SEL_W-1:0] sel_q;
  logic bad_q;
  logic sel_ok;
  logic accept;
  logic reject;
  logic pos_fail;
  logic err_n;
  logic [ROW_W-1:0] word;
  logic [ADDR_W-1:0] slot;

  assign sel_ok = {1'b0, map_sel} < N_MAPS;
  assign word = rom.data[ROW_W*sel_q +: ROW_W];
  assign slot = rom.addr - 4'd1;

`ifdef MAZE_LOADER_CHECK_EN
  maze_pos_check u_pos_check (
    .maze_bits(maze_bits),
    .start_pos(start_pos),
    .end_pos(end_pos),
    .fail(pos_fail)
  );
`else
  assign pos_fail = 1'b0;
`endif

  // a bad select leaves the old image, so its check is moot
  assign err_n = bad_q | pos_fail;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end

  // next-state and load/reject decode
  always_comb begin
    state_n = state;
    accept = 1'b0;
    reject = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_req) begin
          if (sel_ok) begin
            accept = 1'b1;
            state_n = S_FETCH;
          end else begin
            reject = 1'b1;
            state_n = S_CHECK;
          end
        end
      end
      S_FETCH: begin
        if (rom.addr == ADDR_END) state_n = S_DRAIN;
      end
      S_DRAIN: state_n = S_CHECK;
      S_CHECK: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ROM sequencing, image capture and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom.en <= '0;
      rom.addr <= '0;
      sel_q <= '0;
      bad_q <= 1'b0;
      maze_bits <= '0;
      start_pos <= '0;
      end_pos <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      map_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            map_valid <= 1'b0;
            rom.en <= NUM_MAPS'(1) << map_sel;
            rom.addr <= '0;
            sel_q <= map_sel;
            bad_q <= 1'b0;
          end else if (reject) begin
            busy <= 1'b1;
            bad_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (rom.addr != '0) begin
            if (slot == ADDR_START)
              start_pos <= word[POS_W-1:0];
            else
              maze_bits[{slot[2:0], 3'b000} +: ROW_W] <= word;
          end
          if (rom.addr == ADDR_END) rom.en <= '0;
          else rom.addr <= rom.addr + 4'd1;
        end
        S_DRAIN: begin
          end_pos <= word[POS_W-1:0];
        end
        S_CHECK: begin
          done <= 1'b1;
          err <= err_n;
          map_valid <= ~err_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_loader.sv
// tb_maze_loader: random and directed map loads checked
// against a behavioural image/latency model.
module tb_maze_loader;

  localparam int NM = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic load_req;
  logic [1:0] map_sel;
  logic [63:0] maze_bits;
  logic [5:0] start_pos;
  logic [5:0] end_pos;
  logic busy;
  logic done;
  logic err;
  logic map_valid;

  maze_loader_if #(.NUM_MAPS(NM)) rom_bus ();

  maze_loader #(
    .NUM_MAPS(NM),
    .SEL_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_req(load_req),
    .map_sel(map_sel),
    .rom(rom_bus),
    .maze_bits(maze_bits),
    .start_pos(start_pos),
    .end_pos(end_pos),
    .busy(busy),
    .done(done),
    .err(err),
    .map_valid(map_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NM][10];
  logic [NM-1:0] en_q [$];
  logic [3:0] addr_q [$];

  always @(posedge clk) begin
    for (int g = 0; g < NM; g++)
      if (rom_bus.en[g] && rom_bus.addr < 4'd10)
        rom_bus.data[8*g +: 8] <= mem[g][rom_bus.addr];
    if (|rom_bus.en) begin
      en_q.push_back(rom_bus.en);
      addr_q.push_back(rom_bus.addr);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] m_bits;
  logic [5:0] m_start;
  logic [5:0] m_end;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cell_open(input logic [63:0] b,
                                   input logic [5:0] p);
    int r;
    int c;
    r = int'(p[5:3]);
    c = int'(p[2:0]);
    return b[r*8 + c];
  endfunction

  function automatic bit exp_err(input logic [63:0] b,
                                 input logic [5:0] s,
                                 input logic [5:0] e);
`ifdef MAZE_LOADER_CHECK_EN
    return !cell_open(b, s) || !cell_open(b, e) || (s == e);
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_load(input logic [1:0] sel, input bit pulse);
    int n;
    int ndone;
    bit good;
    bit e_err;
    logic [63:0] eb;
    logic [5:0] es;
    logic [5:0] ee;
    logic [NM-1:0] oh;
    good = (int'(sel) < NM);
    oh = NM'(1) << sel;
    if (good) begin
      for (int r = 0; r < 8; r++) eb[r*8 +: 8] = mem[sel][r];
      es = mem[sel][8][5:0];
      ee = mem[sel][9][5:0];
      e_err = exp_err(eb, es, ee);
    end else begin
      eb = m_bits;
      es = m_start;
      ee = m_end;
      e_err = 1'b1;
    end
    @(negedge clk);
    en_q.delete();
    addr_q.delete();
    map_sel = sel;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check("busy_accept", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      load_req = pulse && (n == 4);
      @(posedge clk);
      #1;
      n++;
    end
    load_req = 1'b0;
    check("latency", n, good ? 12 : 1);
    check("done", done, 1);
    check("err", err, e_err);
    check("map_valid", map_valid, !e_err);
    check("busy_done", busy, 1);
    check("maze_bits", maze_bits, eb);
    check("start_pos", start_pos, es);
    check("end_pos", end_pos, ee);
    check("rd_count", en_q.size(), good ? 10 : 0);
    for (int i = 0; i < en_q.size(); i++) begin
      check("rd_addr", addr_q[i], i);
      check("rd_en", en_q[i], oh);
    end
    if (good) begin
      m_bits = eb;
      m_start = es;
      m_end = ee;
    end
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    if (pulse) begin
      ndone = 0;
      repeat (14) begin
        @(posedge clk);
        #1;
        if (done) ndone++;
      end
      check("extra_done", ndone, 0);
      check("extra_reads", en_q.size(), 10);
    end
  endtask

  task automatic open_cell(input int m, input logic [5:0] p);
    mem[m][p[5:3]][p[2:0]] = 1'b1;
  endtask

  initial begin
    int n;
    logic [1:0] sel;
    rst_n = 1'b0;
    load_req = 1'b0;
    map_sel = '0;
    m_bits = '0;
    m_start = '0;
    m_end = '0;
    for (int i = 0; i < NM; i++)
      for (int j = 0; j < 10; j++)
        mem[i][j] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_en", rom_bus.en, 0);
    check("rst_addr", rom_bus.addr, 0);
    check("rst_bits", maze_bits, 0);
    check("rst_start", start_pos, 0);
    check("rst_end", end_pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", map_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // map 2: row0 3F, start row7 col0 (open), end row0 col7
    mem[2][0] = 8'h3F;
    mem[2][7] = mem[2][7] | 8'h01;
    mem[2][8] = 8'b00111000;
    mem[2][9] = 8'b00000111;
    do_load(2'd2, 1'b0);
    check("row0_3f", maze_bits[7:0], 8'h3F);
    check("start_70", start_pos, 6'o70);
    check("end_07", end_pos, 6'o07);

    // start on closed cell
    mem[0][7] = mem[0][7] & 8'hFE;
    mem[0][8] = 8'o070;
    do_load(2'd0, 1'b0);

    // bad select keeps image
    do_load(2'd3, 1'b0);

    // start == end on open cell
    mem[1][8] = 8'hD2;
    mem[1][9] = 8'h12;
    open_cell(1, 6'h12);
    do_load(2'd1, 1'b0);

    // request pulsed mid-fetch is ignored
    do_load(2'd2, 1'b1);

    // held request restarts right after done
    @(negedge clk);
    en_q.delete();
    map_sel = 2'd1;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    check("held_lat1", n, 12);
    check("held_done1", done, 1);
    @(posedge clk);
    #1;
    check("held_restart_en", rom_bus.en, 3'b010);
    check("held_busy", busy, 1);
    load_req = 1'b0;
    wait_done(n);
    check("held_lat2", n, 12);
    check("held_reads", en_q.size(), 20);
    for (int r = 0; r < 8; r++) m_bits[r*8 +: 8] = mem[1][r];
    m_start = mem[1][8][5:0];
    m_end = mem[1][9][5:0];
    check("held_bits", maze_bits, m_bits);
    @(posedge clk);
    #1;

    // reset mid-fetch at address 5
    @(negedge clk);
    map_sel = 2'd0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    n = 0;
    while (rom_bus.addr != 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("addr5_seen", rom_bus.addr, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_en", rom_bus.en, 0);
    check("abort_busy", busy, 0);
    check("abort_bits", maze_bits, 0);
    check("abort_start", start_pos, 0);
    check("abort_end", end_pos, 0);
    check("abort_valid", map_valid, 0);
    check("abort_done", done, 0);
    m_bits = '0;
    m_start = '0;
    m_end = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(2'd0, 1'b0);

    // random maps and selects
    for (int k = 0; k < 16; k++) begin
      sel = 2'($urandom_range(0, 3));
      if (int'(sel) < NM) begin
        for (int j = 0; j < 10; j++) mem[sel][j] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          open_cell(int'(sel), mem[sel][8][5:0]);
          open_cell(int'(sel), mem[sel][9][5:0]);
        end
      end
      do_load(sel, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
